// File: rtl/calc_pkg.sv
// Shared definitions for the calculator mode controllers: DIV state encoding,
// default datapath width and the error-flag value reported on v.
package calc_pkg;

   localparam int DIV_WIDTH = 8;

   // Value driven onto a controller's v output when an operation is rejected.
   localparam logic ERR_FLAG = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   // The partial remainder is always below the divisor, so after the shift it
   // needs WIDTH+1 bits while the restored result fits back into WIDTH bits.
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic [1:0]     unused_top;

   always_comb begin
      shifted  = {rem, dvd_msb};
      diff     = shifted - {1'b0, divisor};
      q_bit    = (shifted >= {1'b0, divisor});
      rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

   assign unused_top = {shifted[WIDTH], diff[WIDTH]};

endmodule

// File: rtl/div_ctrl.sv
// Divide-mode controller: sequential restoring division started by a rising
// edge of div_. Define DIV_SIGNED_EN for two's-complement operands.
module div_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             done,
   output logic             v,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   div_state_e       state_q, state_d;
   logic             div_d_q, div_d_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             done_q, done_d;
   logic             v_q, v_d;
   logic             busy_q, busy_d;
`ifdef DIV_SIGNED_EN
   logic             sgn_quo_q, sgn_quo_d;
   logic             sgn_rem_q, sgn_rem_d;
`endif

   logic             start;
   logic [WIDTH-1:0] rem_nx;
   logic             q_bit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .dvd_msb  (dvd_q[WIDTH-1]),
      .divisor  (dvs_q),
      .rem_next (rem_nx),
      .q_bit    (q_bit)
   );

   assign start = div_ & ~div_d_q & (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      div_d_d = div_;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      done_d  = 1'b0;
      v_d     = v_q;
      busy_d  = busy_q;
`ifdef DIV_SIGNED_EN
      sgn_quo_d = sgn_quo_q;
      sgn_rem_d = sgn_rem_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               v_d    = 1'b0;
               busy_d = 1'b1;
               if (b == '0) begin
                  state_d = DONE;
                  v_d     = ERR_FLAG;
                  q_d     = '0;
                  r_d     = '0;
`ifdef DIV_SIGNED_EN
               end else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
                  state_d = DONE;
                  v_d     = ERR_FLAG;
                  q_d     = a;
                  r_d     = '0;
               end else begin
                  // Divide magnitudes; the signs are reapplied in SIGN.
                  state_d   = CALC;
                  dvd_d     = a[WIDTH-1] ? -a : a;
                  dvs_d     = b[WIDTH-1] ? -b : b;
                  rem_d     = '0;
                  cnt_d     = CW'(WIDTH);
                  sgn_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                  sgn_rem_d = a[WIDTH-1];
               end
`else
               end else begin
                  state_d = CALC;
                  dvd_d   = a;
                  dvs_d   = b;
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH);
               end
`endif
            end
         end

         CALC: begin
            // Quotient bits enter the dividend register from the bottom as the
            // dividend bits leave from the top.
            dvd_d = {dvd_q[WIDTH-2:0], q_bit};
            rem_d = rem_nx;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               q_d = {dvd_q[WIDTH-2:0], q_bit};
               r_d = rem_nx;
`ifdef DIV_SIGNED_EN
               state_d = SIGN;
`else
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
`endif
            end
         end

`ifdef DIV_SIGNED_EN
         SIGN: begin
            if (sgn_quo_q) q_d = -q_q;
            if (sgn_rem_q) r_d = -r_q;
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
`endif

         DONE: begin
            // Error starts jump here without a pulse; emit it on the way out.
            state_d = IDLE;
            if (!done_q) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         div_d_q <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         v_q     <= 1'b0;
         busy_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         sgn_quo_q <= 1'b0;
         sgn_rem_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_d_q <= div_d_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         done_q  <= done_d;
         v_q     <= v_d;
         busy_q  <= busy_d;
`ifdef DIV_SIGNED_EN
         sgn_quo_q <= sgn_quo_d;
         sgn_rem_q <= sgn_rem_d;
`endif
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign done = done_q;
   assign v    = v_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus random operands
// compared against an arithmetic reference model.
module tb_div_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         div_i = 1'b0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic [W-1:0] q_o, r_o;
   logic         done_o, v_o, busy_o;

   int n_cmp = 0;
   int n_err = 0;

   div_ctrl #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .div_ (div_i),
      .a    (a_i),
      .b    (b_i),
      .q    (q_o),
      .r    (r_o),
      .done (done_o),
      .v    (v_o),
      .busy (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: plain integer division; ml = edges from start to done.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 output logic [W-1:0] mq, output logic [W-1:0] mr,
                                 output logic mv, output int ml);
`ifdef DIV_SIGNED_EN
      int sa, sb;
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (mb == '0) begin
         mv = 1'b1; mq = '0; mr = '0; ml = 1;
      end else if (sa == -(1 << (W-1)) && sb == -1) begin
         mv = 1'b1; mq = ma; mr = '0; ml = 1;
      end else begin
         mv = 1'b0; mq = W'(sa / sb); mr = W'(sa % sb); ml = W + 1;
      end
`else
      if (mb == '0) begin
         mv = 1'b1; mq = '0; mr = '0; ml = 1;
      end else begin
         mv = 1'b0; mq = ma / mb; mr = ma % mb; ml = W;
      end
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb);
      logic [W-1:0] eq, er;
      logic         ev;
      int           lat, first, ndone;
      model(opa, opb, eq, er, ev, lat);
      @(negedge clk);
      a_i = opa; b_i = opb; div_i = 1'b1;
      @(posedge clk); #1;
      check("busy_start", busy_o, 1);
      @(negedge clk);
      div_i = 1'b0;
      a_i = W'($urandom);
      b_i = W'($urandom);
      first = -1;
      ndone = 0;
      for (int n = 1; n <= lat + 4; n++) begin
         @(posedge clk); #1;
         if (done_o) begin
            ndone++;
            if (first < 0) begin
               first = n;
               check("q", q_o, eq);
               check("r", r_o, er);
               check("v", v_o, ev);
               check("busy_at_done", busy_o, 0);
            end
         end else if (first < 0 && n < lat) begin
            check("busy_calc", busy_o, 1);
         end
      end
      check("latency", first, lat);
      check("done_count", ndone, 1);
      check("q_hold", q_o, eq);
      check("r_hold", r_o, er);
      check("v_hold", v_o, ev);
      $display("op a=%02h b=%02h -> q=%02h r=%02h v=%0b latency=%0d", opa, opb, q_o, r_o, v_o, first);
   endtask

   initial begin
      logic [W-1:0] eq, er, ta, tb;
      logic         ev;
      int           lat, ndone, sel;
      logic [W-1:0] cq, cr;

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {q_o, r_o, done_o, v_o, busy_o}, '0);
      @(negedge clk);
      rst = 1'b1;

      run_op(8'd100, 8'd7);
      run_op(8'd5, 8'd0);
      repeat (3) @(posedge clk);
      #1;
      check("v_held_after_error", v_o, 1);
      run_op(8'd37, 8'd6);

      // div_ held high: exactly one operation, then a fresh edge restarts.
      model(8'hFF, 8'h01, eq, er, ev, lat);
      @(negedge clk);
      a_i = 8'hFF; b_i = 8'h01; div_i = 1'b1;
      ndone = 0; cq = '0; cr = '0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done_o) begin
            ndone++; cq = q_o; cr = r_o;
         end
      end
      check("held_done_count", ndone, 1);
      check("held_q", cq, eq);
      check("held_r", cr, er);
      $display("op held a=ff b=01 -> q=%02h r=%02h dones=%0d", cq, cr, ndone);
      @(negedge clk);
      div_i = 1'b0;
      run_op(8'hFF, 8'h01);

      // A second edge during CALC is ignored.
      model(8'd200, 8'd3, eq, er, ev, lat);
      @(negedge clk);
      a_i = 8'd200; b_i = 8'd3; div_i = 1'b1;
      @(posedge clk);
      ndone = 0; cq = '0; cr = '0;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         if (n == 1) div_i = 1'b0;
         if (n == 4) begin
            div_i = 1'b1; a_i = 8'd9; b_i = 8'd9;
         end
         @(posedge clk); #1;
         if (done_o) begin
            ndone++; cq = q_o; cr = r_o;
         end
      end
      check("ignored_edge_done_count", ndone, 1);
      check("ignored_edge_q", cq, eq);
      check("ignored_edge_r", cr, er);
      $display("op a=c8 b=03 with late edge -> q=%02h r=%02h dones=%0d", cq, cr, ndone);
      @(negedge clk);
      div_i = 1'b0;

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      a_i = 8'd50; b_i = 8'd5; div_i = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      div_i = 1'b0;
      #1;
      check("midop_reset_outputs", {q_o, r_o, done_o, v_o, busy_o}, '0);
      @(negedge clk);
      rst = 1'b1;
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (done_o) ndone++;
      end
      check("no_done_after_reset", ndone, 0);
      $display("op a=32 b=05 aborted by reset, dones afterwards=%0d", ndone);
      run_op(8'd50, 8'd5);

`ifdef DIV_SIGNED_EN
      run_op(8'hF9, 8'h02);
      run_op(8'h80, 8'hFF);
      run_op(8'h80, 8'h01);
      run_op(8'h07, 8'hFE);
`endif

      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 9));
         ta = W'($urandom);
         tb = W'($urandom);
         if (sel == 0) tb = '0;
         if (sel == 1) begin
            ta = 8'h80; tb = 8'hFF;
         end
         if (sel == 2) tb = W'($urandom_range(1, 3));
         run_op(ta, tb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
